// File: rtl/ex_stall_sequencer_pkg.sv
// ex_stall_sequencer_pkg: shared class/state enums for the EX-stage stall sequencer.
package ex_stall_sequencer_pkg;
  localparam int EX_CLASS_WIDTH = 2;
  typedef enum logic [EX_CLASS_WIDTH-1:0] {CLS_NONE, CLS_MUL, CLS_DIV, CLS_MEM} ex_class_e;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_KILL} ex_seq_state_e;
endpackage

// File: rtl/ex_stall_timer.sv
// ex_stall_timer: 8-bit counter with clear, enable and terminal-count compare.
module ex_stall_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] tc_val,
  output logic       tc
);
  logic [7:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
  assign tc = cnt == tc_val;
endmodule

// File: rtl/ex_stall_sequencer.sv
// ex_stall_sequencer: starts MUL/DIV/MEM units, stalls EX until done, kills on flush/timeout.
// Define EX_STALL_PERF_EN to add the 32-bit stallCycles performance counter.
module ex_stall_sequencer
  import ex_stall_sequencer_pkg::*;
#(
  parameter int MAX_BUSY_CYCLES = 255,
  parameter int KILL_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issueValid,
  input  logic [EX_CLASS_WIDTH-1:0] issueClass,
  input  logic                      flushReq,
  input  logic                      mulDone,
  input  logic                      divDone,
  input  logic                      memDone,
  output logic                      mulStart,
  output logic                      divStart,
  output logic                      memStart,
  output logic                      unitKill,
  output logic                      exStallReq,
  output logic [EX_CLASS_WIDTH-1:0] busyClass,
`ifdef EX_STALL_PERF_EN
  output logic [31:0]               stallCycles,
`endif
  output logic                      timeoutError
);
  ex_seq_state_e state;
  ex_class_e cls;
  logic tc, clr, issue, done, in_wait, wait_done, timeout;
  always_comb begin
    in_wait = state == ST_WAIT;
    issue = state == ST_IDLE && issueValid && issueClass != CLS_NONE && !flushReq;
    done = cls == CLS_MUL ? mulDone : cls == CLS_DIV ? divDone : cls == CLS_MEM ? memDone : 1'b0;
    wait_done = in_wait && !flushReq && done;
    timeout = in_wait && !flushReq && !done && tc;
    mulStart = issue && issueClass == CLS_MUL;
    divStart = issue && issueClass == CLS_DIV;
    memStart = issue && issueClass == CLS_MEM;
    unitKill = (in_wait && flushReq) || timeout;
    exStallReq = issue || (in_wait && !flushReq && !done) || state == ST_KILL;
    clr = state == ST_IDLE || (in_wait && (flushReq || done || tc)) || (state == ST_KILL && tc);
  end
  // One timer serves both the WAIT timeout and the KILL dwell.
  ex_stall_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .en    (!clr),
    .tc_val(state == ST_KILL ? 8'(KILL_CYCLES - 1) : 8'(MAX_BUSY_CYCLES - 1)),
    .tc    (tc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      cls <= CLS_NONE;
      timeoutError <= 1'b0;
    end else if (issue) begin
      state <= ST_WAIT;
      cls <= ex_class_e'(issueClass);
    end else if (in_wait && flushReq) state <= ST_KILL;
    else if (wait_done || (state == ST_KILL && tc)) begin
      state <= ST_IDLE;
      cls <= CLS_NONE;
    end else if (timeout) begin
      state <= ST_KILL;
      timeoutError <= 1'b1;
    end
  assign busyClass = cls;
`ifdef EX_STALL_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) stallCycles <= '0;
    else if (exStallReq) stallCycles <= stallCycles + 32'd1;
`endif
endmodule
